// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator producing sign-extended imm and pc+imm target
// Ports: clk, rst_n (async active-low), flush (sync kill of held entries);
//        in_valid/in_ready/in_inst/in_imm_type/in_pc upstream handshake and payload;
//        out_valid/out_ready/out_imm/out_target/out_imm_type downstream handshake and payload.
// imm_type encoding: 1=I 2=S 3=B 4=U 5=J, anything else = no immediate.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_imm_type,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_imm_type
);
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x, tgt_x;
    logic            m_v, s_v, acc, adv;
    logic [XLEN-1:0] m_imm, m_tgt, s_imm, s_tgt;
    logic [2:0]      m_ty, s_ty;

    // every 32-bit format already carries inst[31] in bit 31, so one sign-extension covers all
    always_comb
        imm32 = in_imm_type == IMM_I ? {{20{in_inst[31]}}, in_inst[31:20]} :
                in_imm_type == IMM_S ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
                in_imm_type == IMM_B ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                in_imm_type == IMM_U ? {in_inst[31:12], 12'b0} :
                in_imm_type == IMM_J ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                32'd0;

    assign imm_x = XLEN'($signed(imm32));
    assign tgt_x = in_pc + imm_x;

    // main register can load when empty or draining; the skid only ever fills when it cannot
    assign adv      = !m_v || out_ready;
    assign in_ready = (SKID != 0) ? !s_v : adv;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v   <= 1'b0;
            s_v   <= 1'b0;
            m_imm <= '0;
            m_tgt <= '0;
            m_ty  <= '0;
            s_imm <= '0;
            s_tgt <= '0;
            s_ty  <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (adv) begin
            if (s_v) begin
                m_v   <= 1'b1;
                m_imm <= s_imm;
                m_tgt <= s_tgt;
                m_ty  <= s_ty;
                s_v   <= 1'b0;
            end else begin
                m_v <= acc;
                if (acc) begin
                    m_imm <= imm_x;
                    m_tgt <= tgt_x;
                    m_ty  <= in_imm_type;
                end
            end
        end else if (acc) begin
            s_v   <= 1'b1;
            s_imm <= imm_x;
            s_tgt <= tgt_x;
            s_ty  <= in_imm_type;
        end
    end

    assign out_valid    = m_v;
    assign out_imm      = m_imm;
    assign out_target   = m_tgt;
    assign out_imm_type = m_ty;
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage between the fetch/decode front end and the execute stage.
- Accepts one instruction per cycle with its decoded immType_e and PC over a valid/ready handshake.
- Produces the XLEN-wide sign-extended immediate and the PC-relative target (pc + imm).
- Supports RV32 and RV64, with an optional 2-entry skid buffer so the upstream in_ready is a registered signal.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64 only; any other value is a synthesis-time error.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline kill; discards all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_inst  input  32  raw instruction word.
- in_imm_type  input  immType_e  immediate format (I/S/B/U/J; any other encoding = none).
- in_pc  input  XLEN  PC of in_inst.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the output entry.
- out_imm  output  XLEN  sign-extended immediate.
- out_target  output  XLEN  in_pc + immediate, modulo 2^XLEN.
- out_imm_type  output  immType_e  in_imm_type carried alongside.

Behaviour:
- Immediate field extraction (bit-exact):
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Every format, including U, is sign-extended from inst[31] to XLEN bits.
- Any imm_type other than I/S/B/U/J: imm = 0, so target = pc.
- Target = pc + imm for all types. Carry out of bit XLEN-1 is discarded (wrap-around). JALR rs1 correction is not done here.
- Latency: 1 cycle. An entry accepted at edge N (in_valid && in_ready) is presented on out_* from edge N onward, i.e. visible in cycle N+1.
- Handshake:
  - A transfer occurs on any edge where valid && ready are both 1.
  - While out_valid=1 and out_ready=0, every out_* signal holds stable.
  - out_valid never drops without a transfer, except on flush or reset.
  - in_valid may be asserted irrespective of in_ready.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Full throughput of 1 entry/cycle under continuous out_ready.
- SKID=1:
  - Main register plus skid register.
  - in_ready = !skid_valid, registered.
  - If an entry is accepted while the main register is valid and out_ready=0, the entry goes to the skid register.
  - When the main register drains, the skid entry moves to main on the same edge.
  - Order is strictly FIFO; no entry is lost or duplicated.
  - With both registers full: in_ready=0.
- Simultaneous accept and drain, main-only state: the new entry replaces main and skid stays empty.
- Flush:
  - On the edge with flush=1, main and skid valids clear; out_valid=0 next cycle.
  - An input accepted in the same cycle is dropped; flush takes priority.
  - in_ready=1 after a flush edge.
  - A downstream transfer in the flush cycle still counts as completed.
- Reset:
  - rst_n low asynchronously forces out_valid=0, skid_valid=0, out_imm=0, out_target=0, out_imm_type=0.
  - In-flight entries are lost when reset asserts mid-operation.
  - in_ready=1 while in reset and after release.
- Data registers may be non-reset only if out_* reads 0 whenever out_valid=0 after reset; otherwise they must reset to 0.

Test Plan:
- Formats, XLEN=32:
  - I 0xFFF00093, pc 0x100 -> imm 0xFFFFFFFF, target 0x000000FF.
  - S 0xFE112C23 -> imm 0xFFFFFFF8.
  - B 0xFE000EE3, pc 0x200 -> imm 0xFFFFFFFC, target 0x1FC.
  - All appear one cycle after acceptance.
- Wrap and RV64:
  - XLEN=32, J 0x0080006F, pc 0xFFFFFFFC -> imm 0x8, target 0x00000004.
  - XLEN=64, U 0x800000B7, pc 0x1000 -> imm 0xFFFFFFFF80000000, target 0xFFFFFFFF80001000.
- Backpressure, SKID=1:
  - Hold out_ready=0 and stream 3 entries A, B, C.
  - A sits in main and B in skid; in_ready=0 from the edge after B; C is held upstream.
  - Release out_ready: outputs A, B, C in order with no gaps or duplicates.
  - Repeat with SKID=0: in_ready tracks out_ready combinationally.
- Throughput: 16 back-to-back entries with out_ready=1 -> 16 outputs on 16 consecutive cycles; in_ready never deasserts.
- Flush: with main+skid full, pulse flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Reset and unknown type:
  - Assert rst_n low mid-stream, asynchronously between edges -> out_valid=0, out_imm=0 immediately.
  - Illegal imm_type with pc 0x40 -> imm 0, target 0x40.
